// File: rtl/decode_pkg.sv
// Shared encodings for the multicycle control decoder: FSM states, ALU ops,
// data-processing cmd codes and datapath mux selects.
package decode_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_EXMUL, S_EXDIV, S_ALUWB, S_BRANCH
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_DIV = 3'b101;
  localparam logic [2:0] ALU_EOR = 3'b110;
  localparam logic [2:0] ALU_MOV = 3'b111;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MUL = 4'b1111;
  localparam logic [3:0] CMD_DIV = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCA_RN       = 2'b00;
  localparam logic [1:0] SRCA_PC       = 2'b01;
  localparam logic [1:0] SRCB_RM       = 2'b00;
  localparam logic [1:0] SRCB_IMM      = 2'b01;
  localparam logic [1:0] SRCB_FOUR     = 2'b10;

  // Map a data-processing cmd to its ALU operation; unknown cmds add.
  function automatic logic [2:0] alu_ctrl(input logic [3:0] cmd);
    logic [2:0] r;
    case (cmd)
      CMD_ADD: r = ALU_ADD;
      CMD_SUB: r = ALU_SUB;
      CMD_AND: r = ALU_AND;
      CMD_ORR: r = ALU_ORR;
      CMD_MUL: r = ALU_MUL;
      CMD_DIV: r = ALU_DIV;
      CMD_EOR: r = ALU_EOR;
      CMD_MOV: r = ALU_MOV;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_mc_if.sv
// Instruction fields and divider handshake in, datapath controls out.
interface decode_mc_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       DivDone;
  logic       isShift;
  logic [1:0] FlagW;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [2:0] ALUControl;
  logic       DivStart;
  logic       Busy;
  logic       IllegalOp;

  modport master (
    output Op, Funct, Rd, DivDone,
    input  isShift, FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, DivStart, Busy, IllegalOp
  );

  modport slave (
    input  Op, Funct, Rd, DivDone,
    output isShift, FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, DivStart, Busy, IllegalOp
  );
endinterface

// File: rtl/mainfsm_mc.sv
// Main control FSM: state register, MUL latency counter, divider start flag
// and the per-state datapath controls.
module mainfsm_mc
  import decode_pkg::*;
#(
  parameter int unsigned MUL_LAT    = 3,
  parameter bit          ENABLE_DIV = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_op,
  input  logic [5:0] i_funct,
  input  logic       i_div_done,
  output logic       o_irwrite_c,
  output logic       o_nextpc_c,
  output logic       o_adrsrc_c,
  output logic       o_regw_c,
  output logic       o_memw_c,
  output logic       o_branch_c,
  output logic       o_aluop_c,
  output logic       o_busy_c,
  output logic       o_illegal_op_c,
  output logic [1:0] o_resultsrc_c,
  output logic [1:0] o_alusrca_c,
  output logic [1:0] o_alusrcb_c,
  output logic       o_div_start
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_mul_cnt;
  logic             r_div_start;
  logic [3:0]       w_cmd;

  assign w_cmd       = i_funct[4:1];
  assign o_div_start = r_div_start;

  // Counter sits at 0 outside EXMUL so it always enters EXMUL cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_FETCH;
      r_mul_cnt   <= '0;
      r_div_start <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_mul_cnt   <= (r_state == S_EXMUL) ? r_mul_cnt + CNT_W'(1) : '0;
      r_div_start <= (r_state == S_DECODE) && (w_next == S_EXDIV);
    end
  end

  always_comb begin
    w_next         = r_state;
    o_irwrite_c    = 1'b0;
    o_nextpc_c     = 1'b0;
    o_adrsrc_c     = 1'b0;
    o_regw_c       = 1'b0;
    o_memw_c       = 1'b0;
    o_branch_c     = 1'b0;
    o_aluop_c      = 1'b0;
    o_busy_c       = 1'b0;
    o_illegal_op_c = 1'b0;
    o_resultsrc_c  = RES_ALUOUT;
    o_alusrca_c    = SRCA_RN;
    o_alusrcb_c    = SRCB_RM;
    case (r_state)
      S_FETCH: begin
        o_irwrite_c   = 1'b1;
        o_nextpc_c    = 1'b1;
        o_alusrca_c   = SRCA_PC;
        o_alusrcb_c   = SRCB_FOUR;
        o_resultsrc_c = RES_ALURESULT;
        w_next        = S_DECODE;
      end
      S_DECODE: begin
        o_alusrca_c   = SRCA_PC;
        o_alusrcb_c   = SRCB_FOUR;
        o_resultsrc_c = RES_ALURESULT;
        case (i_op)
          OP_MEM: w_next = S_MEMADR;
          OP_BR:  w_next = S_BRANCH;
          OP_ILL: begin
            w_next         = S_FETCH;
            o_illegal_op_c = 1'b1;
          end
          default: begin
            if (i_funct[5])                          w_next = S_EXECI;
            else if (w_cmd == CMD_MUL)               w_next = S_EXMUL;
            else if (w_cmd == CMD_DIV && ENABLE_DIV) w_next = S_EXDIV;
            else                                     w_next = S_EXECR;
          end
        endcase
      end
      S_MEMADR: begin
        o_alusrcb_c = SRCB_IMM;
        w_next      = i_funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        o_adrsrc_c = 1'b1;
        w_next     = S_MEMWB;
      end
      S_MEMWB: begin
        o_resultsrc_c = RES_DATA;
        o_regw_c      = 1'b1;
        w_next        = S_FETCH;
      end
      S_MEMWR: begin
        o_adrsrc_c = 1'b1;
        o_memw_c   = 1'b1;
        w_next     = S_FETCH;
      end
      S_EXECR: begin
        o_aluop_c = 1'b1;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        o_aluop_c   = 1'b1;
        o_alusrcb_c = SRCB_IMM;
        w_next      = S_ALUWB;
      end
      S_EXMUL: begin
        o_aluop_c = 1'b1;
        o_busy_c  = 1'b1;
        if (r_mul_cnt == CNT_W'(MUL_LAT - 1)) w_next = S_ALUWB;
      end
      S_EXDIV: begin
        o_aluop_c = 1'b1;
        o_busy_c  = 1'b1;
        if (i_div_done) w_next = S_ALUWB;
      end
      S_ALUWB: begin
        o_regw_c = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        o_alusrcb_c   = SRCB_IMM;
        o_resultsrc_c = RES_ALURESULT;
        o_branch_c    = 1'b1;
        w_next        = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

endmodule

// File: rtl/decode_mc.sv
// Multicycle control decoder: main FSM plus combinational ALU decoder,
// PC-source logic and instruction-field decode.
module decode_mc
  import decode_pkg::*;
#(
  parameter int unsigned MUL_LAT    = 3,
  parameter bit          ENABLE_DIV = 1'b1
) (
  input logic         clk,
  input logic         reset,
  decode_mc_if.slave  bus
);

  logic       w_regw;
  logic       w_branch;
  logic       w_aluop;
  logic [3:0] w_cmd;
  logic       w_s;
  logic [2:0] w_alu_ctrl;
  logic [1:0] w_flagw;
  logic [1:0] w_regsrc;

  mainfsm_mc #(
    .MUL_LAT    (MUL_LAT),
    .ENABLE_DIV (ENABLE_DIV)
  ) u_fsm (
    .clk            (clk),
    .reset          (reset),
    .i_op           (bus.Op),
    .i_funct        (bus.Funct),
    .i_div_done     (bus.DivDone),
    .o_irwrite_c    (bus.IRWrite),
    .o_nextpc_c     (bus.NextPC),
    .o_adrsrc_c     (bus.AdrSrc),
    .o_regw_c       (w_regw),
    .o_memw_c       (bus.MemW),
    .o_branch_c     (w_branch),
    .o_aluop_c      (w_aluop),
    .o_busy_c       (bus.Busy),
    .o_illegal_op_c (bus.IllegalOp),
    .o_resultsrc_c  (bus.ResultSrc),
    .o_alusrca_c    (bus.ALUSrcA),
    .o_alusrcb_c    (bus.ALUSrcB),
    .o_div_start    (bus.DivStart)
  );

  assign w_cmd = bus.Funct[4:1];
  assign w_s   = bus.Funct[0];

  // Flag enables come from cmd directly so MUL/DIV never touch C/V.
  always_comb begin
    w_alu_ctrl = ALU_ADD;
    w_flagw    = 2'b00;
    if (w_aluop) begin
      w_alu_ctrl = alu_ctrl(w_cmd);
      w_flagw    = {w_s, w_s & ((w_cmd == CMD_ADD) | (w_cmd == CMD_SUB))};
    end
  end

  always_comb begin
    case (bus.Op)
      OP_MEM:  w_regsrc = 2'b10;
      OP_BR:   w_regsrc = 2'b01;
      default: w_regsrc = 2'b00;
    endcase
  end

  assign bus.RegW       = w_regw;
  assign bus.ALUControl = w_alu_ctrl;
  assign bus.FlagW      = w_flagw;
  assign bus.RegSrc     = w_regsrc;
  assign bus.ImmSrc     = bus.Op;
  assign bus.isShift    = (bus.Op == OP_DP) && (w_cmd == CMD_MOV);
  assign bus.PCS        = ((bus.Rd == 4'hF) & w_regw) | w_branch;

endmodule
